// File: rtl/ldst_cmd_queue.sv
// Buffers rf_ldst load/store commands in a FIFO and issues them one at a time, each waiting for done.
// Latency: push to start pulse is 2 edges when the queue is empty; optional LDST_CMD_PERF_EN adds busy_cycles.
// Backpressure: cmd_ready = !full; a pop frees a slot only on the following edge.

module ldst_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module ldst_cmd_queue #(
  parameter int RF_ADDR_W    = 10,
  parameter int SDRAM_ADDR_W = 32,
  parameter int LINE_NUM_W   = 11,
  parameter int DEPTH        = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_store,
  input  logic [RF_ADDR_W-1:0]      cmd_rf_addr,
  input  logic [SDRAM_ADDR_W-1:0]   cmd_sdram_addr,
  input  logic [LINE_NUM_W-1:0]     cmd_line_num,
  output logic                      load_start,
  output logic                      store_start,
  output logic [RF_ADDR_W-1:0]      rf_addr,
  output logic [SDRAM_ADDR_W-1:0]   sdram_addr,
  output logic [LINE_NUM_W-1:0]     line_num,
  input  logic                      done,
  output logic                      busy,
  output logic                      idle,
  output logic [$clog2(DEPTH):0]    pending,
  output logic [15:0]               retired
`ifdef LDST_CMD_PERF_EN
  ,
  output logic [31:0]               busy_cycles
`endif
);
  localparam int PW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic                    store;
    logic [RF_ADDR_W-1:0]    rf_addr;
    logic [SDRAM_ADDR_W-1:0] sdram_addr;
    logic [LINE_NUM_W-1:0]   line_num;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t state;
  cmd_t   push_cmd;
  cmd_t   head;
  logic   push;
  logic   pop;
  logic   empty;
  logic   done_q;

  assign push_cmd  = '{store: cmd_store, rf_addr: cmd_rf_addr,
                       sdram_addr: cmd_sdram_addr, line_num: cmd_line_num};
  assign cmd_ready = (pending != PW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign empty     = (pending == '0);
  assign pop       = (state == S_IDLE) && !empty;
  assign busy      = (state != S_IDLE);
  assign idle      = empty && !busy;

  ldst_cmd_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_cmd),
    .pop      (pop),
    .head_dat (head),
    .count    (pending)
  );

  // Zero-length commands retire straight from IDLE without touching rf_ldst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      load_start  <= 1'b0;
      store_start <= 1'b0;
      rf_addr     <= '0;
      sdram_addr  <= '0;
      line_num    <= '0;
      retired     <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= done;
      load_start  <= 1'b0;
      store_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            rf_addr    <= head.rf_addr;
            sdram_addr <= head.sdram_addr;
            line_num   <= head.line_num;
            if (head.line_num == '0) begin
              retired <= retired + 16'd1;
            end else begin
              state       <= S_ISSUE;
              load_start  <= !head.store;
              store_start <= head.store;
            end
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (done && !done_q) begin
            retired <= retired + 16'd1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LDST_CMD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                busy_cycles <= '0;
    else if (busy && (busy_cycles != '1))      busy_cycles <= busy_cycles + 32'd1;
  end
`endif
endmodule
